// File: rtl/seg7_mon_if.sv
// Bundle of signals between a 7-segment decode monitor and its environment.
// The slave side is the monitor: it samples the segment bus and produces
// decoded events. The master side drives segments and accepts events.
interface seg7_mon_if;
    logic [6:0] seg_in;
    logic       seg_strobe;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_hex;
    logic       out_blank;
    logic       out_err;
    logic       overflow;

    modport master (
        output seg_in, seg_strobe, out_ready,
        input  out_valid, out_hex, out_blank, out_err, overflow
    );

    modport slave (
        input  seg_in, seg_strobe, out_ready,
        output out_valid, out_hex, out_blank, out_err, overflow
    );
endinterface

// File: rtl/seg7_decode_mon.sv
// Seven-segment readback monitor: filters an active-low segment bus for
// stability, decodes each newly stable glyph back to hex (or blank/error)
// and presents it as an event on a valid/ready port with sticky overflow.
module seg7_decode_mon #(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg7_mon_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);
    localparam logic [6:0]       BLANK    = 7'h7F;

    typedef struct packed {
        logic [3:0] hex;
        logic       blank;
        logic       err;
    } dec_t;

    // Inverse of the hex-to-segment encoder; blank and unknown patterns
    // report hex 0 with the matching flag.
    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d = '{hex: 4'h0, blank: 1'b0, err: 1'b0};
        case (pat)
            7'h40: d.hex = 4'h0;
            7'h79: d.hex = 4'h1;
            7'h24: d.hex = 4'h2;
            7'h30: d.hex = 4'h3;
            7'h19: d.hex = 4'h4;
            7'h12: d.hex = 4'h5;
            7'h02: d.hex = 4'h6;
            7'h78: d.hex = 4'h7;
            7'h00: d.hex = 4'h8;
            7'h10: d.hex = 4'h9;
            7'h08: d.hex = 4'hA;
            7'h03: d.hex = 4'hB;
            7'h46: d.hex = 4'hC;
            7'h21: d.hex = 4'hD;
            7'h06: d.hex = 4'hE;
            7'h0E: d.hex = 4'hF;
            BLANK: d.blank = 1'b1;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

    logic [1:0]       state, state_nx;
    logic [6:0]       cand, cand_nx;
    logic [6:0]       last;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             commit;

    // Commit pipeline stage between the filter and the output port.
    logic             commit_q;
    logic [6:0]       commit_pat;

    logic             valid_q;
    dec_t             evt_q;
    logic             overflow_q;

    dec_t             commit_dec;
    assign commit_dec = decode(commit_pat);

    // Stability filter next-state: restart on any new pattern, count
    // repeats, commit when the count reaches STABLE_CNT.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        commit   = 1'b0;
        if (bus.seg_strobe) begin
            unique case (state)
                TRACK: begin
                    if (bus.seg_in == cand) begin
                        cnt_nx = cnt + ONE_V;
                        if (cnt + ONE_V == STABLE_V) begin
                            commit   = 1'b1;
                            state_nx = HOLD;
                        end
                    end else begin
                        cand_nx  = bus.seg_in;
                        cnt_nx   = ONE_V;
                        commit   = (STABLE_V == ONE_V);
                        state_nx = commit ? HOLD : TRACK;
                    end
                end
                HOLD: begin
                    if (bus.seg_in != last) begin
                        cand_nx  = bus.seg_in;
                        cnt_nx   = ONE_V;
                        commit   = (STABLE_V == ONE_V);
                        state_nx = commit ? HOLD : TRACK;
                    end
                end
                default: begin
                    cand_nx  = bus.seg_in;
                    cnt_nx   = ONE_V;
                    commit   = (STABLE_V == ONE_V);
                    state_nx = commit ? HOLD : TRACK;
                end
            endcase
        end
    end

    // Filter state, last committed glyph and the commit pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= IDLE;
            cand       <= BLANK;
            cnt        <= '0;
            last       <= BLANK;
            commit_q   <= 1'b0;
            commit_pat <= BLANK;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            cnt      <= cnt_nx;
            commit_q <= commit;
            if (commit) begin
                last       <= cand_nx;
                commit_pat <= cand_nx;
            end
        end
    end

    // Output event register: load on commit, drop on transfer, flag
    // overwrites of an event the consumer has not yet taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            evt_q      <= '{hex: 4'h0, blank: 1'b0, err: 1'b0};
            overflow_q <= 1'b0;
        end else if (commit_q) begin
            valid_q <= 1'b1;
            evt_q   <= commit_dec;
            if (valid_q && !bus.out_ready) begin
                overflow_q <= 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_hex   = evt_q.hex;
    assign bus.out_blank = evt_q.blank;
    assign bus.out_err   = evt_q.err;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_decode_mon.sv
// Directed bench for seg7_decode_mon (STABLE_CNT=3): filter latency,
// duplicate suppression, glitch restart, overwrite/overflow, blank/error
// decode, reset mid-track and commit coinciding with transfer.
module tb_seg7_decode_mon;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    seg7_mon_if bus ();

    seg7_decode_mon #(.STABLE_CNT(3), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [3:0] hex,
                             input logic blank, input logic err);
        check({tag, ".valid"}, 8'(bus.out_valid), 8'h01);
        check({tag, ".hex"},   8'(bus.out_hex),   8'(hex));
        check({tag, ".blank"}, 8'(bus.out_blank), 8'(blank));
        check({tag, ".err"},   8'(bus.out_err),   8'(err));
    endtask

    task automatic check_novalid(input string tag);
        check({tag, ".valid"}, 8'(bus.out_valid), 8'h00);
    endtask

    task automatic check_ovf(input string tag, input logic exp);
        check({tag, ".ovf"}, 8'(bus.overflow), 8'(exp));
    endtask

    // Apply inputs for one cycle, then look at outputs just after the edge.
    task automatic drive(input logic [6:0] pat, input logic stb, input logic rdy);
        bus.seg_in     = pat;
        bus.seg_strobe = stb;
        bus.out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.seg_in     = 7'h7F;
        bus.seg_strobe = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state
        rst = 1'b1;
        drive(7'h40, 1'b1, 1'b1);
        drive(7'h40, 1'b1, 1'b1);
        check("rst.valid", 8'(bus.out_valid), 8'h00);
        check("rst.hex",   8'(bus.out_hex),   8'h00);
        check("rst.blank", 8'(bus.out_blank), 8'h00);
        check("rst.err",   8'(bus.out_err),   8'h00);
        check_ovf("rst", 1'b0);
        rst = 1'b0;

        // Glyph 0 stable for three strobes, event one cycle later
        for (int i = 0; i < 3; i++) begin
            drive(7'h40, 1'b1, 1'b1);
            check_novalid($sformatf("g0.s%0d", i));
        end
        drive(7'h40, 1'b0, 1'b1);
        check_evt("g0.evt", 4'h0, 1'b0, 1'b0);
        drive(7'h40, 1'b0, 1'b1);
        check_novalid("g0.taken");
        // Uninterrupted hold suppresses duplicates
        for (int i = 0; i < 10; i++) drive(7'h40, 1'b1, 1'b1);
        drive(7'h40, 1'b0, 1'b1);
        check_novalid("g0.hold_a");
        drive(7'h40, 1'b0, 1'b1);
        check_novalid("g0.hold_b");

        // 79,79 never stabilise; 24 x3 gives exactly one event
        drive(7'h79, 1'b1, 1'b1); check_novalid("g2.s0");
        drive(7'h79, 1'b1, 1'b1); check_novalid("g2.s1");
        drive(7'h24, 1'b1, 1'b1); check_novalid("g2.s2");
        drive(7'h24, 1'b1, 1'b1); check_novalid("g2.s3");
        drive(7'h24, 1'b1, 1'b1); check_novalid("g2.s4");
        drive(7'h24, 1'b0, 1'b1);
        check_evt("g2.evt", 4'h2, 1'b0, 1'b0);
        drive(7'h24, 1'b0, 1'b1);
        check_novalid("g2.taken");

        // F pending with consumer stalled, then overwritten by C
        for (int i = 0; i < 3; i++) drive(7'h0E, 1'b1, 1'b0);
        drive(7'h0E, 1'b0, 1'b0);
        check_evt("gF.evt", 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(7'h46, 1'b1, 1'b0);
            check_evt($sformatf("gF.held%0d", i), 4'hF, 1'b0, 1'b0);
            check_ovf($sformatf("gF.held%0d", i), 1'b0);
        end
        drive(7'h46, 1'b0, 1'b0);
        check_evt("gC.evt", 4'hC, 1'b0, 1'b0);
        check_ovf("gC.evt", 1'b1);
        drive(7'h46, 1'b0, 1'b1);
        check_novalid("gC.taken");
        check_ovf("gC.taken", 1'b1);

        // Blank and error patterns
        for (int i = 0; i < 3; i++) drive(7'h7F, 1'b1, 1'b1);
        drive(7'h7F, 1'b0, 1'b1);
        check_evt("blank.evt", 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(7'h55, 1'b1, 1'b1);
        drive(7'h55, 1'b0, 1'b1);
        check_evt("err.evt", 4'h0, 1'b0, 1'b1);
        drive(7'h55, 1'b0, 1'b1);
        check_novalid("err.taken");
        check_ovf("err.taken", 1'b1);

        // Reset mid-track discards the candidate and clears overflow
        drive(7'h00, 1'b1, 1'b1);
        drive(7'h00, 1'b1, 1'b1);
        rst = 1'b1;
        drive(7'h00, 1'b1, 1'b1);
        rst = 1'b0;
        check_novalid("rst2");
        check_ovf("rst2", 1'b0);
        drive(7'h00, 1'b1, 1'b1);
        drive(7'h00, 1'b0, 1'b1); check_novalid("g8.p1");
        drive(7'h00, 1'b1, 1'b1);
        drive(7'h00, 1'b0, 1'b1); check_novalid("g8.p2");
        drive(7'h00, 1'b1, 1'b1);
        drive(7'h00, 1'b0, 1'b1);
        check_evt("g8.evt", 4'h8, 1'b0, 1'b0);
        drive(7'h00, 1'b0, 1'b1);

        // Strobe gaps hold the count; event 9 stays pending (ready low)
        drive(7'h10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(7'h3C, 1'b0, 1'b0);
        check_novalid("g9.gap1");
        drive(7'h10, 1'b1, 1'b0);
        drive(7'h3C, 1'b0, 1'b0);
        check_novalid("g9.gap2");
        drive(7'h10, 1'b1, 1'b0);
        drive(7'h10, 1'b0, 1'b0);
        check_evt("g9.evt", 4'h9, 1'b0, 1'b0);

        // Commit lands in the same cycle as transfer: back-to-back valid
        for (int i = 0; i < 3; i++) drive(7'h24, 1'b1, 1'b0);
        check_evt("b2b.pend", 4'h9, 1'b0, 1'b0);
        drive(7'h24, 1'b0, 1'b1);
        check_evt("b2b.evt", 4'h2, 1'b0, 1'b0);
        check_ovf("b2b", 1'b0);
        drive(7'h24, 1'b0, 1'b1);
        check_novalid("b2b.taken");

        // Glitch through TRACK re-commits the same glyph
        drive(7'h30, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(7'h24, 1'b1, 1'b1);
        drive(7'h24, 1'b0, 1'b1);
        check_evt("recommit", 4'h2, 1'b0, 1'b0);
        drive(7'h24, 1'b0, 1'b1);
        check_novalid("recommit.taken");
        check_ovf("recommit", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_decode_mon.md
Name: seg7_decode_mon

Overview:
- Monitor and decoder for one 7-segment digit. It is the inverse of the team's hex-to-segment encoder.
- Samples an active-low segment bus (bit0=a … bit6=g, 0 = lit), qualifies it with a stability filter, and decodes it back to a 4-bit hex value.
- Each new stable glyph is presented on a valid/ready output port.
- Used in self-checking display paths and to read back display content for scoring/debug.

Parameters:
- STABLE_CNT, 3, number of consecutive equal qualified samples required before a glyph is committed (legal range 1–15).
- CNT_W, 4, width of the stability counter; must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high. Every register takes its reset value on the first clk edge with rst=1.
- seg_in  input  7  active-low segments; seg_in[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.
- seg_strobe  input  1  sample qualifier; seg_in is ignored in cycles where seg_strobe=0.
- out_ready  input  1  consumer accepts the current event.
- out_valid  output  1  event pending.
- out_hex  output  4  decoded nibble; 0 when the event is blank or error.
- out_blank  output  1  event is the all-off pattern 7'h7F.
- out_err  output  1  event is a pattern that is neither a hex glyph nor blank.
- overflow  output  1  sticky; an event was overwritten before it was accepted.

Behaviour:
- Decode table (seg_in → hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F → blank
  - any other value → error
- Registers: cand (7 bits), cnt (CNT_W bits), last (7 bits), state.
- FSM states:
  - IDLE: no candidate. On strobe: cand←seg_in, cnt←1, go to TRACK. If STABLE_CNT=1, commit on this same sample.
  - TRACK: strobe with seg_in==cand → cnt+1. When cnt+1==STABLE_CNT, commit and go to HOLD. Strobe with seg_in≠cand → cand←seg_in, cnt←1, stay in TRACK.
  - HOLD: strobe with seg_in==last → stay; no event. Strobe with seg_in≠last → cand←seg_in, cnt←1, go to TRACK.
- No strobe in any state: hold all registers.
- Commit: last←cand. The event fields are registered from cand's decode, and out_valid=1 is asserted on the next edge.
- Latency: an event appears 1 clk after the edge that samples the STABLE_CNT-th equal strobed sample.
- Re-commit rule: a glyph that re-stabilises to the same value as last (e.g. via a glitch through TRACK) does commit again. Only an uninterrupted HOLD suppresses duplicates.
- Handshake:
  - out_valid, out_hex, out_blank and out_err hold stable while out_valid=1 and out_ready=0.
  - Transfer happens on an edge with out_valid=1 and out_ready=1; out_valid then drops, unless a commit occurs in the same cycle.
- Simultaneous commit and transfer: the new event is loaded, out_valid stays 1, and overflow is not set.
- Commit while out_valid=1 and out_ready=0: the new event overwrites the pending one and overflow←1. overflow clears only on rst.
- Reset values: out_valid=0, out_hex=0, out_blank=0, out_err=0, overflow=0, state=IDLE, cnt=0, cand=7'h7F, last=7'h7F.
- Reset mid-TRACK: candidate discarded; the next strobe restarts counting from 1.
- Counter never exceeds STABLE_CNT; it is not updated while in HOLD.

Test Plan:
- rst, then seg_in=40 strobed 3 consecutive cycles with out_ready=1 → one cycle later out_valid=1, out_hex=0, out_blank=0, out_err=0; then valid drops; 10 further strobes of 40 → no event.
- Strobes 79, 79, 24, 24, 24 → single event out_hex=2; no event for 1.
- Strobes 0E×3 with out_ready=0, then 46×3 → first event F held stable until overwritten; then out_hex=C and overflow=1; overflow stays 1 after acceptance until rst.
- Strobes 7F×3 → out_blank=1, out_hex=0. Strobes 55×3 → out_err=1, out_hex=0.
- Strobes 00, 00, then rst for 1 cycle, then 00 → no event until 2 more strobes of 00 (3 post-reset samples) → out_hex=8.
- Strobe gaps: 10, idle 5 cycles, 10, idle, 10 → event 9 after the third strobe. Commit coinciding with out_ready=1 on a pending event → back-to-back valid, overflow=0.
